// File: rtl/light_pkg.sv
// Shared mode encodings, count sizing and lamp decode for the light mode
// controller and its display driver.
package light_pkg;

    localparam int unsigned COUNT_MAX = 99999;
    localparam int unsigned COUNT_W   = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUN     = 3'd1,
        YELLOW  = 3'd2,
        WHITE   = 3'd3,
        WAITSUN = 3'd4,
        WAITYLW = 3'd5,
        WAITWHT = 3'd6
    } mode_t;

    // {white, yellow, sun}; a WAITx state keeps the previous lamp lit.
    function automatic logic [2:0] lamp_of(input mode_t m);
        logic [2:0] l;
        l = 3'b000;
        case (m)
            SUN:     l = 3'b001;
            YELLOW:  l = 3'b010;
            WHITE:   l = 3'b100;
            WAITYLW: l = 3'b001;
            WAITWHT: l = 3'b010;
            default: l = 3'b000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/light_timer.sv
// Millisecond down-counter with load, decrement and one-cycle expire flag.
module light_timer
    import light_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               expire_c
);

    // Expiry fires on the tick that would take the count from 1 to 0.
    assign expire_c = dec && (count == COUNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - COUNT_W'(1);
        end
    end

endmodule

// File: rtl/light_mode_ctrl.sv
// Mode-key light controller: confirm window, lit period and lamp drive.
// Lit-state auto-off timing is enabled by defining LIGHT_AUTO_OFF_EN.
module light_mode_ctrl
    import light_pkg::*;
#(
    parameter int unsigned WAIT_MS = 3000,
    parameter int unsigned ON_MS   = 60000
) (
    input  logic               Sys_CLK,
    input  logic               Sys_RST,
    input  logic               ms_tick,
    input  logic               key_pulse,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] count,
    output logic [2:0]         lamp
);

    localparam logic [COUNT_W-1:0] WAIT_VAL = COUNT_W'(WAIT_MS);
`ifdef LIGHT_AUTO_OFF_EN
    localparam logic [COUNT_W-1:0] LIT_VAL  = COUNT_W'(ON_MS);
    localparam logic               LIT_TICK = 1'b1;
`else
    localparam logic [COUNT_W-1:0] LIT_VAL  = '0;
    localparam logic               LIT_TICK = 1'b0;
`endif

    mode_t              mode_q;
    mode_t              next_c;
    logic               tick_en_c;
    logic               dec_c;
    logic               load_c;
    logic [COUNT_W-1:0] load_val_c;
    logic               expire_c;

    assign state = mode_q;

    // Key beats tick: a key cycle never decrements.
    assign dec_c = ms_tick && tick_en_c && !key_pulse;

    light_timer u_timer (
        .clk      (Sys_CLK),
        .rst      (Sys_RST),
        .load     (load_c),
        .load_val (load_val_c),
        .dec      (dec_c),
        .count    (count),
        .expire_c (expire_c)
    );

    always_comb begin
        tick_en_c = 1'b0;
        case (mode_q)
            SUN, YELLOW, WHITE:        tick_en_c = LIT_TICK;
            WAITSUN, WAITYLW, WAITWHT: tick_en_c = 1'b1;
            default:                   tick_en_c = 1'b0;
        endcase
    end

    always_comb begin
        next_c = mode_q;
        case (mode_q)
            IDLE:    if (key_pulse) next_c = WAITSUN;
            SUN:     if (key_pulse) next_c = WAITYLW;
                     else if (expire_c) next_c = IDLE;
            YELLOW:  if (key_pulse) next_c = WAITWHT;
                     else if (expire_c) next_c = IDLE;
            WHITE:   if (key_pulse || expire_c) next_c = IDLE;
            WAITSUN: if (key_pulse || expire_c) next_c = SUN;
            WAITYLW: if (key_pulse || expire_c) next_c = YELLOW;
            WAITWHT: if (key_pulse || expire_c) next_c = WHITE;
            default: next_c = IDLE;
        endcase
    end

    // Every transition reloads the timer with the entry value of the new mode.
    always_comb begin
        load_c     = (next_c != mode_q);
        load_val_c = '0;
        case (next_c)
            WAITSUN, WAITYLW, WAITWHT: load_val_c = WAIT_VAL;
            SUN, YELLOW, WHITE:        load_val_c = LIT_VAL;
            default:                   load_val_c = '0;
        endcase
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            mode_q <= IDLE;
            lamp   <= 3'b000;
        end else begin
            mode_q <= next_c;
            lamp   <= lamp_of(next_c);
        end
    end

endmodule

// File: doc/light_mode_ctrl.md
LIGHT_MODE_CTRL -- requirements
Module: light_mode_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MS, default 3000: confirm-window length in ms ticks, legal range 1..99999.
REQ-002 SHALL have parameter ON_MS, default 60000: lit-period length in ms ticks, legal range 1..99999.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 SHALL have port Sys_CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port Sys_RST, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port ms_tick, input, 1 bit: 1 kHz enable pulse, one Sys_CLK wide.
REQ-007 SHALL have port key_pulse, input, 1 bit: debounced mode-key press, one Sys_CLK wide.
REQ-008 SHALL have port state, output, 3 bits: current mode, to the display driver.
REQ-009 SHALL have port count, output, 20 bits: remaining time in ms, binary, to the display driver.
REQ-010 SHALL have port lamp, output, 3 bits: {white, yellow, sun} lamp drives.

Function
REQ-011 SHALL encode state as IDLE=0, SUN=1, YELLOW=2, WHITE=3, WAITSUN=4, WAITYLW=5, WAITWHT=6; code 7 SHALL go to IDLE on the next cycle.
REQ-012 SHALL, on key_pulse: IDLE->WAITSUN, SUN->WAITYLW, YELLOW->WAITWHT and WHITE->IDLE; in WAITx it SHALL go to the matching lit state.
REQ-013 SHALL load count=WAIT_MS on entering any WAITx state, load count=ON_MS on entering any lit state, and set count=0 in IDLE.
REQ-014 SHALL decrement count by 1 on each ms_tick in non-IDLE states; count=1 with ms_tick SHALL cause the timeout transition instead of reaching 0.
REQ-015 SHALL make WAITx timeout go to the matching lit state, and lit-state timeout go to IDLE.
REQ-016 SHALL give key_pulse priority when it coincides with ms_tick: the key transition applies and count is loaded for the new state, not decremented.
REQ-017 SHALL register state, count and lamp outputs, which update in the same cycle as the transition; latency from input pulse to output is 1 cycle.
REQ-018 SHALL drive lamp as: SUN 001, YELLOW 010, WHITE 100, IDLE 000, WAITSUN 000, WAITYLW 001, WAITWHT 010.
REQ-019 SHALL hold count and state unchanged on cycles with neither tick nor key.

Reset
REQ-020 SHALL, with Sys_RST high at a clock edge, force state=IDLE, count=0 and lamp=000, overriding key_pulse and ms_tick.
REQ-021 SHALL start from IDLE when reset is asserted mid-countdown, and ignore a key_pulse coincident with the reset cycle.

Configuration
REQ-022 SHALL use the macro LIGHT_AUTO_OFF_EN; when it is defined, lit states time out per REQ-014/015.
REQ-023 SHALL, when LIGHT_AUTO_OFF_EN is undefined, set count=0 in lit states, ignore ms_tick there, and leave lit states only by key; WAITx timing is unchanged.

Structure
REQ-024 SHALL place the state encodings and the 99999 count ceiling in the shared package light_pkg, also used by the display driver.
REQ-025 SHALL implement the down-counter, with load, decrement and expire, in sub-module light_timer; the FSM stays in light_mode_ctrl.

Verification (WAIT_MS=3, ON_MS=5, macro defined unless noted)
REQ-026 SHALL check: reset, then key -> state 4, count 3, lamp 000; 3 ticks -> state 1, count 5, lamp 001.
REQ-027 SHALL check: in SUN, 5 ticks -> count 4,3,2,1, then state 0, count 0, lamp 000.
REQ-028 SHALL check: in WAITYLW with count 2, key and tick in the same cycle -> state 2, count 5.
REQ-029 SHALL check: key sequence from IDLE through 7 presses -> states 4,1,5,2,6,3,0.
REQ-030 SHALL check: in YELLOW with count 3, assert Sys_RST together with key -> state 0, count 0, lamp 000.
REQ-031 SHALL check, with macro undefined: in WHITE, 10 ticks -> state 3, count 0, lamp 100 unchanged.
